cape_stream: RTL and testbench

Handshaked, parametrised successor to the CAPE stochastic-number generator. On each run it latches `NUM_INPUTS` binary operands and a precision. It then streams one `NUM_INPUTS`-bit stochastic sample per accepted beat from a bit-interleaved shared counter. When `ET_EN=1`, counter bits made redundant by operand trailing zeros or by truncation are skipped, which shortens the run. It sits between the operand register file and downstream SC arithmetic, and adds start/valid/ready flow control, abort, a `last` marker and a reported run length.

---
 rtl/cape_pkg.sv | 31 +++
 rtl/cape_stream_if.sv | 32 +++
 rtl/cape_skip_ctr.sv | 49 ++++
 rtl/cape_stream.sv | 134 +++++++++++++
 tb/tb_cape_stream.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cape_pkg.sv
// Shared types and helpers for the cape_stream stochastic-number generator.
package cape_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cape_state_e;

  // Trailing-zero count of the low w bits of v; an all-zero value reports w.
  function automatic int unsigned cape_tz(input logic [31:0] v, input int unsigned w);
    int unsigned n;
    bit          hit;
    n   = w;
    hit = 1'b0;
    for (int unsigned j = 0; j < 32; j++) begin
      if ((j < w) && !hit && v[j[4:0]]) begin
        n   = j;
        hit = 1'b1;
      end
    end
    return n;
  endfunction

  // Shared counter bit that carries bit j of channel i.
  function automatic int unsigned cape_ilv_idx(input int unsigned i, input int unsigned j,
                                               input int unsigned n);
    return j * n + i;
  endfunction

endpackage

// File: rtl/cape_stream_if.sv
// Start/operand request and sample stream bundle for cape_stream.
interface cape_stream_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_INPUTS = 8
);
  localparam int unsigned CW = WIDTH * NUM_INPUTS;
  localparam int unsigned PW = $clog2(WIDTH + 1);
  localparam int unsigned RW = $clog2(CW + 1);

  logic                  start;
  logic                  start_ready;
  logic [WIDTH-1:0]      Bxs [NUM_INPUTS];
  logic [PW-1:0]         prec;
  logic                  abort;
  logic                  x_valid;
  logic                  x_ready;
  logic [NUM_INPUTS-1:0] Xs;
  logic                  last;
  logic                  done;
  logic [RW-1:0]         run_len_log2;

  modport master (
    output start, Bxs, prec, abort, x_ready,
    input  start_ready, x_valid, Xs, last, done, run_len_log2
  );

  modport slave (
    input  start, Bxs, prec, abort, x_ready,
    output start_ready, x_valid, Xs, last, done, run_len_log2
  );

endinterface

// File: rtl/cape_skip_ctr.sv
// Shared sample counter whose skipped bits stay zero and pass the carry through.
module cape_skip_ctr #(
  parameter int unsigned CW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          kill,
  input  logic          adv,
  input  logic [CW-1:0] skip,
  output logic [CW-1:0] count_c,
  output logic          last,
  output logic          ovf_c
);
  logic [CW-1:0] cnt;
  logic [CW-1:0] mask;
  logic [CW-1:0] inc;

  // Forcing skipped bits to 1 lets a plain +1 ripple straight through them.
  always_comb begin
    inc     = ((cnt | mask) + CW'(1)) & ~mask;
    ovf_c   = adv & (&(cnt | mask));
    count_c = cnt;
    if (kill || load) begin
      count_c = '0;
    end else if (adv) begin
      count_c = inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      mask <= '0;
      last <= 1'b0;
    end else begin
      cnt <= count_c;
      if (kill) begin
        last <= 1'b0;
      end else if (load) begin
        mask <= skip;
        last <= &skip;
      end else if (adv) begin
        last <= &(inc | mask);
      end
    end
  end

endmodule

// File: rtl/cape_stream.sv
// Handshaked stochastic-number stream: latches operands on start, then emits
// one comparison sample per accepted beat from an interleaved skip counter.
module cape_stream
  import cape_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_INPUTS = 8,
  parameter bit          ET_EN      = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  cape_stream_if.slave bus
);
  localparam int unsigned CW = WIDTH * NUM_INPUTS;
  localparam int unsigned PW = $clog2(WIDTH + 1);
  localparam int unsigned RW = $clog2(CW + 1);
  localparam int unsigned IW = (CW > 1) ? $clog2(CW) : 1;

  cape_state_e           state, state_nxt;
  logic                  load, kill, hs, ovf_c, last;
  logic [CW-1:0]         count_c, skip_new;
  logic [PW-1:0]         prec_eff;
  logic [WIDTH-1:0]      keep;
  logic [WIDTH-1:0]      bm_new [NUM_INPUTS];
  logic [WIDTH-1:0]      bm_q   [NUM_INPUTS];
  logic [RW-1:0]         len_new, run_len_q;
  logic [NUM_INPUTS-1:0] xs_nxt, xs_q;
  logic                  x_valid_q, done_q, start_ready_q;

  assign hs = x_valid_q & bus.x_ready;

  // Truncated operands are zero below the kept MSBs, so their trailing-zero
  // count already covers the truncation part of the skip rule.
  always_comb begin
    int unsigned tz;
    prec_eff = (ET_EN && (bus.prec < PW'(WIDTH))) ? bus.prec : PW'(WIDTH);
    keep     = ~((WIDTH'(1) << (PW'(WIDTH) - prec_eff)) - WIDTH'(1));
    skip_new = '0;
    len_new  = '0;
    tz       = 0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      bm_new[i] = bus.Bxs[i] & keep;
      tz        = ET_EN ? cape_tz(32'(bm_new[i]), WIDTH) : 0;
      len_new   = len_new + RW'(WIDTH - tz);
      for (int unsigned j = 0; j < WIDTH; j++) begin
        skip_new[IW'(cape_ilv_idx(i, j, NUM_INPUTS))] = (j < tz);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    kill      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (ovf_c) begin
          kill      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next sample from the count and operands that will be live next cycle.
  always_comb begin
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] bm;
    xs_nxt = '0;
    v      = '0;
    bm     = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      v = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
        v[j] = count_c[IW'(cape_ilv_idx(i, j, NUM_INPUTS))];
      end
      bm        = load ? bm_new[i] : bm_q[i];
      xs_nxt[i] = (state_nxt == RUN) && (v < bm);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x_valid_q     <= 1'b0;
      xs_q          <= '0;
      done_q        <= 1'b0;
      start_ready_q <= 1'b1;
      run_len_q     <= '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) bm_q[i] <= '0;
    end else begin
      state         <= state_nxt;
      x_valid_q     <= (state_nxt == RUN);
      xs_q          <= xs_nxt;
      done_q        <= (state_nxt == DONE);
      start_ready_q <= (state_nxt == IDLE);
      if (load) begin
        bm_q      <= bm_new;
        run_len_q <= len_new;
      end
    end
  end

  cape_skip_ctr #(.CW(CW)) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .kill    (kill),
    .adv     (hs),
    .skip    (skip_new),
    .count_c (count_c),
    .last    (last),
    .ovf_c   (ovf_c)
  );

  assign bus.start_ready  = start_ready_q;
  assign bus.x_valid      = x_valid_q;
  assign bus.Xs           = xs_q;
  assign bus.last         = last;
  assign bus.done         = done_q;
  assign bus.run_len_log2 = run_len_q;

endmodule

// File: tb/tb_cape_stream.sv
// Bench for cape_stream (WIDTH=4, NUM_INPUTS=2) with early termination on and off.
module tb_cape_stream;
  localparam int W  = 4;
  localparam int N  = 2;
  localparam int CW = W * N;

  logic       clk;
  logic       rst_n;
  bit         sel;
  logic       start, abort, x_ready;
  logic [3:0] b0, b1;
  logic [2:0] prec;

  cape_stream_if #(.WIDTH(W), .NUM_INPUTS(N)) ife ();
  cape_stream_if #(.WIDTH(W), .NUM_INPUTS(N)) ifn ();

  cape_stream #(.WIDTH(W), .NUM_INPUTS(N), .ET_EN(1'b1)) dut_et (
    .clk(clk), .rst_n(rst_n), .bus(ife.slave));
  cape_stream #(.WIDTH(W), .NUM_INPUTS(N), .ET_EN(1'b0)) dut_ne (
    .clk(clk), .rst_n(rst_n), .bus(ifn.slave));

  assign ife.start = start && !sel;
  assign ifn.start = start && sel;
  assign ife.Bxs[0] = b0;
  assign ife.Bxs[1] = b1;
  assign ifn.Bxs[0] = b0;
  assign ifn.Bxs[1] = b1;
  assign ife.prec = prec;
  assign ifn.prec = prec;
  assign ife.abort = abort;
  assign ifn.abort = abort;
  assign ife.x_ready = x_ready;
  assign ifn.x_ready = x_ready;

  logic       o_xv, o_last, o_done, o_sr;
  logic [1:0] o_xs;
  logic [3:0] o_len;
  assign o_xv   = sel ? ifn.x_valid      : ife.x_valid;
  assign o_xs   = sel ? ifn.Xs           : ife.Xs;
  assign o_last = sel ? ifn.last         : ife.last;
  assign o_done = sel ? ifn.done         : ife.done;
  assign o_sr   = sel ? ifn.start_ready  : ife.start_ready;
  assign o_len  = sel ? ifn.run_len_log2 : ife.run_len_log2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cnt_cmp = 0;
  int cnt_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cnt_cmp++;
    if (act !== exp) begin
      cnt_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    cnt_cmp++;
    cnt_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: the s-th sample deposits the bits of s, LSB first, into the
  // unskipped counter positions in ascending interleaved order.
  int m_bm[2];
  int m_L;
  int m_pos[$];

  task automatic model_setup(input int a0, input int a1, input int p, input bit et);
    int pe, keep, tz, i, j;
    pe   = (!et || p > W) ? W : p;
    keep = ((1 << W) - 1) & ~((1 << (W - pe)) - 1);
    m_bm[0] = a0 & keep;
    m_bm[1] = a1 & keep;
    m_pos.delete();
    for (int k = 0; k < CW; k++) begin
      i  = k % N;
      j  = k / N;
      tz = W;
      for (int b = W - 1; b >= 0; b--) if (((m_bm[i] >> b) & 1) != 0) tz = b;
      if (!et || (j >= W - pe && j >= tz)) m_pos.push_back(k);
    end
    m_L = m_pos.size();
  endtask

  function automatic logic [1:0] model_xs(input int s);
    int v[2];
    int k;
    logic [1:0] r;
    v[0] = 0;
    v[1] = 0;
    for (int b = 0; b < m_L; b++) begin
      if (((s >> b) & 1) != 0) begin
        k = m_pos[b];
        v[k % N] |= 1 << (k / N);
      end
    end
    r[0] = (v[0] < m_bm[0]);
    r[1] = (v[1] < m_bm[1]);
    return r;
  endfunction

  // One run on the selected DUT; called and returning at #1 after a clock edge.
  task automatic do_run(input logic [3:0] a0, input logic [3:0] a1, input logic [2:0] p,
                        input int stall_at, input bit rnd, input int abort_at, input bit poke,
                        output int n0, output int n1, output int ns, output int ncyc,
                        output int len_obs);
    int s, last_idx, stall_left;
    logic [1:0] held_xs;
    logic held_last;
    bit stalled;
    model_setup(int'(a0), int'(a1), int'(p), !sel);
    last_idx = (1 << m_L) - 1;
    n0 = 0; n1 = 0; ns = 0; ncyc = 0; len_obs = 0;
    s = 0; stall_left = 3; stalled = 1'b0;
    held_xs = '0; held_last = 1'b0;
    chk("start_ready_idle", o_sr, 1);
    b0 = a0; b1 = a1; prec = p; start = 1'b1; x_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    len_obs = int'(o_len);
    chk("run_len_log2", o_len, m_L);
    forever begin
      if (ncyc > 1500) begin
        fail("run_timeout");
        return;
      end
      if (o_xv !== 1'b1) begin
        chk("x_valid_in_run", o_xv, 1);
        return;
      end
      ncyc++;
      chk("Xs", o_xs, model_xs(s));
      chk("last", o_last, (s == last_idx));
      if (stalled) begin
        chk("stall_hold_Xs", o_xs, held_xs);
        chk("stall_hold_last", o_last, held_last);
      end
      if (s == abort_at) begin
        abort = 1'b1;
        x_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_x_valid", o_xv, 0);
        chk("abort_start_ready", o_sr, 1);
        chk("abort_done", o_done, 0);
        repeat (2) begin
          @(posedge clk); #1;
          chk("abort_no_done", o_done, 0);
        end
        return;
      end
      if (rnd) x_ready = ($urandom_range(0, 3) != 0);
      else     x_ready = !(s == stall_at && stall_left > 0);
      if (!x_ready) stall_left--;
      held_xs   = o_xs;
      held_last = o_last;
      stalled   = !x_ready;
      if (poke && s == 2) begin
        start = 1'b1;
        b0 = ~a0;
        b1 = ~a1;
      end
      if (x_ready) begin
        if (o_xs[0]) n0++;
        if (o_xs[1]) n1++;
        ns++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      b0 = a0;
      b1 = a1;
      if (x_ready && s == last_idx) break;
      if (x_ready) s++;
    end
    chk("done_pulse", o_done, 1);
    chk("done_x_valid", o_xv, 0);
    chk("done_start_ready", o_sr, 0);
    @(posedge clk); #1;
    chk("done_clears", o_done, 0);
    chk("back_to_idle", o_sr, 1);
  endtask

  typedef struct {
    logic [3:0] b0;
    logic [3:0] b1;
    logic [2:0] p;
    int         len;
    int         ones0;
    int         ones1;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int n0, n1, ns, ncyc, len;
    logic [3:0] r0, r1;
    logic [2:0] rp;

    tbl[0] = '{b0: 4'b1000, b1: 4'b0100, p: 3'd4, len: 3, ones0: 4,  ones1: 2};
    tbl[1] = '{b0: 4'b0000, b1: 4'b0000, p: 3'd4, len: 0, ones0: 0,  ones1: 0};
    tbl[2] = '{b0: 4'b0111, b1: 4'b1111, p: 3'd2, len: 4, ones0: 4,  ones1: 12};
    tbl[3] = '{b0: 4'b0101, b1: 4'b1001, p: 3'd0, len: 0, ones0: 0,  ones1: 0};
    tbl[4] = '{b0: 4'b0001, b1: 4'b0011, p: 3'd7, len: 8, ones0: 16, ones1: 48};

    rst_n = 1'b0; sel = 1'b0; start = 1'b0; abort = 1'b0; x_ready = 1'b0;
    b0 = '0; b1 = '0; prec = '0;
    #12;
    chk("rst_x_valid", o_xv, 0);
    chk("rst_Xs", o_xs, 0);
    chk("rst_last", o_last, 0);
    chk("rst_done", o_done, 0);
    chk("rst_start_ready", o_sr, 1);
    chk("rst_run_len", o_len, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      do_run(tbl[t].b0, tbl[t].b1, tbl[t].p, -1, 1'b0, -1, 1'b0, n0, n1, ns, ncyc, len);
      chk("tbl_run_len", len, tbl[t].len);
      chk("tbl_samples", ns, 1 << tbl[t].len);
      chk("tbl_ones_ch0", n0, tbl[t].ones0);
      chk("tbl_ones_ch1", n1, tbl[t].ones1);
      chk("tbl_run_cycles", ncyc, 1 << tbl[t].len);
    end

    // Stall for three cycles while the fifth sample is presented.
    do_run(4'b1000, 4'b0100, 3'd4, 4, 1'b0, -1, 1'b0, n0, n1, ns, ncyc, len);
    chk("stall_samples", ns, 8);
    chk("stall_ones_ch0", n0, 4);
    chk("stall_ones_ch1", n1, 2);
    chk("stall_run_cycles", ncyc, 11);

    // Abort while the third sample is presented, then rerun and poke start mid-run.
    do_run(4'b1000, 4'b0100, 3'd4, -1, 1'b0, 2, 1'b0, n0, n1, ns, ncyc, len);
    chk("abort_accepted", ns, 2);
    do_run(4'b1000, 4'b0100, 3'd4, -1, 1'b0, -1, 1'b0, n0, n1, ns, ncyc, len);
    chk("rerun_samples", ns, 8);
    chk("rerun_ones_ch0", n0, 4);
    chk("rerun_ones_ch1", n1, 2);
    do_run(4'b1000, 4'b0100, 3'd4, -1, 1'b0, -1, 1'b1, n0, n1, ns, ncyc, len);
    chk("poke_samples", ns, 8);
    chk("poke_ones_ch0", n0, 4);
    chk("poke_ones_ch1", n1, 2);

    for (int t = 0; t < 8; t++) begin
      r0 = 4'($urandom_range(0, 15));
      r1 = 4'($urandom_range(0, 15));
      rp = 3'($urandom_range(0, 7));
      do_run(r0, r1, rp, -1, 1'b1, -1, 1'b0, n0, n1, ns, ncyc, len);
      chk("rnd_samples", ns, 1 << m_L);
    end

    sel = 1'b1;
    do_run(4'b1000, 4'b0100, 3'd2, -1, 1'b0, -1, 1'b0, n0, n1, ns, ncyc, len);
    chk("noet_run_len", len, 8);
    chk("noet_samples", ns, 256);
    chk("noet_ones_ch0", n0, 128);
    chk("noet_ones_ch1", n1, 64);

    // Asynchronous reset between clock edges in the middle of a long run.
    b0 = 4'b1000; b1 = 4'b0100; prec = 3'd2; start = 1'b1; x_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    chk("pre_reset_x_valid", o_xv, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x_valid", o_xv, 0);
    chk("mid_rst_Xs", o_xs, 0);
    chk("mid_rst_last", o_last, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_start_ready", o_sr, 1);
    chk("mid_rst_run_len", o_len, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    sel = 1'b0;
    do_run(4'b1000, 4'b0100, 3'd4, -1, 1'b0, -1, 1'b0, n0, n1, ns, ncyc, len);
    chk("post_reset_samples", ns, 8);
    chk("post_reset_ones_ch0", n0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
    $finish;
  end

endmodule
